// File: rtl/pkt_sched_pkg.sv
// Shared state encoding and default sizing for the packet scheduler.
package pkt_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int unsigned DEF_HDR_DIBITS     = 12;
    localparam int unsigned DEF_PIXEL_DIBITS   = 1280;
    localparam int unsigned DEF_GAP_CYCLES     = 48;
    localparam int unsigned DEF_PKTS_PER_FRAME = 240;
    localparam int unsigned MIN_DIBIT_CNT_W    = 11;

    // Dibit counter never narrower than 11 bits, wider if the packet needs it.
    function automatic int unsigned dibit_cnt_width(input int unsigned total);
        int unsigned w;
        w = $clog2(total);
        return (w > MIN_DIBIT_CNT_W) ? w : MIN_DIBIT_CNT_W;
    endfunction

endpackage

// File: rtl/pkt_gap_timer.sv
// Loadable down-counter timing the inter-packet gap; done_o is high on the
// last gap cycle so the owner can leave GAP on that edge.
module pkt_gap_timer
    import pkt_sched_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int unsigned CNT_W      = $clog2(GAP_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic load_i,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(GAP_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/packet_scheduler.sv
// Frame/packet sequencer driving the dibit serializer stall line.
// Define PACKET_SCHEDULER_STATS_EN to add the frames_sent/aborts_seen counters.
module packet_scheduler
    import pkt_sched_pkg::*;
#(
    parameter int unsigned HDR_DIBITS     = DEF_HDR_DIBITS,
    parameter int unsigned PIXEL_DIBITS   = DEF_PIXEL_DIBITS,
    parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int unsigned PKTS_PER_FRAME = DEF_PKTS_PER_FRAME
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_req,
    input  logic       tx_ready,
    input  logic       ser_axiov,
    output logic       stall,
    output logic       busy,
    output logic       pkt_start,
    output logic       pkt_done,
    output logic       frame_done,
    output logic       aborted,
    output logic       overrun,
    output logic [7:0] pkt_count
`ifdef PACKET_SCHEDULER_STATS_EN
    ,
    output logic [15:0] frames_sent,
    output logic [7:0]  aborts_seen
`endif
);

    localparam int unsigned DIBIT_CNT_W = dibit_cnt_width(HDR_DIBITS + PIXEL_DIBITS);
    localparam logic [DIBIT_CNT_W-1:0] LAST_DIBIT = DIBIT_CNT_W'(HDR_DIBITS + PIXEL_DIBITS - 1);
    localparam logic [7:0] LAST_PKT = 8'(PKTS_PER_FRAME - 1);

    state_e                 state_q, state_d;
    logic [DIBIT_CNT_W-1:0] dib_cnt_q, dib_cnt_d;
    logic [7:0]             pkt_count_q, pkt_count_d;
    logic                   stall_q, stall_d;
    logic                   busy_q, busy_d;
    logic                   pkt_start_q, pkt_start_d;
    logic                   pkt_done_q, pkt_done_d;
    logic                   frame_done_q, frame_done_d;
    logic                   aborted_q, aborted_d;
    logic                   overrun_q, overrun_d;
    logic                   gap_load, gap_clr, gap_done;

    pkt_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gap_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (gap_clr),
        .load_i(gap_load),
        .done_o(gap_done)
    );

    always_comb begin
        state_d      = state_q;
        dib_cnt_d    = dib_cnt_q;
        pkt_count_d  = pkt_count_q;
        pkt_start_d  = 1'b0;
        pkt_done_d   = 1'b0;
        frame_done_d = 1'b0;
        aborted_d    = 1'b0;
        overrun_d    = 1'b0;
        gap_load     = 1'b0;
        gap_clr      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_req && tx_ready) begin
                    state_d     = ST_SEND;
                    dib_cnt_d   = '0;
                    pkt_count_d = '0;
                    pkt_start_d = 1'b1;
                end
            end
            ST_SEND: begin
                if (ser_axiov) begin
                    if (dib_cnt_q == LAST_DIBIT) begin
                        state_d    = ST_GAP;
                        dib_cnt_d  = '0;
                        pkt_done_d = 1'b1;
                        gap_load   = 1'b1;
                    end else begin
                        dib_cnt_d = dib_cnt_q + DIBIT_CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    if (pkt_count_q == LAST_PKT) begin
                        state_d      = ST_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d     = ST_SEND;
                        pkt_count_d = pkt_count_q + 8'd1;
                        pkt_start_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Link loss overrides whatever the active state decided this cycle.
        if (state_q != ST_IDLE) begin
            overrun_d = frame_req;
            if (!tx_ready) begin
                state_d      = ST_IDLE;
                dib_cnt_d    = '0;
                pkt_count_d  = pkt_count_q;
                pkt_start_d  = 1'b0;
                pkt_done_d   = 1'b0;
                frame_done_d = 1'b0;
                gap_load     = 1'b0;
                gap_clr      = 1'b1;
                aborted_d    = 1'b1;
            end
        end

        stall_d = (state_d != ST_SEND);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dib_cnt_q    <= '0;
            pkt_count_q  <= '0;
            stall_q      <= 1'b1;
            busy_q       <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            aborted_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            dib_cnt_q    <= dib_cnt_d;
            pkt_count_q  <= pkt_count_d;
            stall_q      <= stall_d;
            busy_q       <= busy_d;
            pkt_start_q  <= pkt_start_d;
            pkt_done_q   <= pkt_done_d;
            frame_done_q <= frame_done_d;
            aborted_q    <= aborted_d;
            overrun_q    <= overrun_d;
        end
    end

    assign stall      = stall_q;
    assign busy       = busy_q;
    assign pkt_start  = pkt_start_q;
    assign pkt_done   = pkt_done_q;
    assign frame_done = frame_done_q;
    assign aborted    = aborted_q;
    assign overrun    = overrun_q;
    assign pkt_count  = pkt_count_q;

`ifdef PACKET_SCHEDULER_STATS_EN
    logic [15:0] frames_sent_q, frames_sent_d;
    logic [7:0]  aborts_seen_q, aborts_seen_d;

    always_comb begin
        frames_sent_d = frames_sent_q;
        aborts_seen_d = aborts_seen_q;
        if (frame_done_d) begin
            frames_sent_d = frames_sent_q + 16'd1;
        end
        if (aborted_d && (aborts_seen_q != '1)) begin
            aborts_seen_d = aborts_seen_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frames_sent_q <= '0;
            aborts_seen_q <= '0;
        end else begin
            frames_sent_q <= frames_sent_d;
            aborts_seen_q <= aborts_seen_d;
        end
    end

    assign frames_sent = frames_sent_q;
    assign aborts_seen = aborts_seen_q;
`endif

endmodule

// File: tb/tb_packet_scheduler.sv
// Scoreboard bench for packet_scheduler with GAP_CYCLES=4, PKTS_PER_FRAME=3.
module tb_packet_scheduler;

    localparam int DONE_OFS = 1293;  // 1 cycle serializer lag + 1292 dibits
    localparam int PERIOD   = 1297;  // DONE_OFS + 4 gap cycles
    localparam int FRAME_END = 3 * PERIOD;

    typedef struct {
        int kind;
        int cyc;
        int pc;
    } ev_t;

    logic clk = 1'b0;
    logic rst, frame_req, tx_ready, ser_axiov;
    logic stall, busy, pkt_start, pkt_done, frame_done, aborted, overrun;
    logic [7:0] pkt_count;
`ifdef PACKET_SCHEDULER_STATS_EN
    logic [15:0] frames_sent;
    logic [7:0]  aborts_seen;
`endif

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    int  block_left = 0;
    ev_t exp_q[$];

    packet_scheduler #(
        .HDR_DIBITS    (12),
        .PIXEL_DIBITS  (1280),
        .GAP_CYCLES    (4),
        .PKTS_PER_FRAME(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .frame_req (frame_req),
        .tx_ready  (tx_ready),
        .ser_axiov (ser_axiov),
        .stall     (stall),
        .busy      (busy),
        .pkt_start (pkt_start),
        .pkt_done  (pkt_done),
        .frame_done(frame_done),
        .aborted   (aborted),
        .overrun   (overrun),
        .pkt_count (pkt_count)
`ifdef PACKET_SCHEDULER_STATS_EN
        ,
        .frames_sent(frames_sent),
        .aborts_seen(aborts_seen)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            0: return "pkt_start";
            1: return "pkt_done";
            2: return "frame_done";
            3: return "overrun";
            default: return "aborted";
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int c, input int pc);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input int p, input int shift, input bit ovr);
        push(0, p, 0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) push(0, p + PERIOD * k + shift, k);
            push(1, p + DONE_OFS + PERIOD * k + shift, k);
            if (ovr && k == 0) push(3, p + DONE_OFS + 1, 0);
        end
        push(2, p + FRAME_END + shift, 2);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic pulse_req(input int p);
        wait_cyc(p - 1);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
    endtask

    // Serializer model: valid follows !stall one cycle late, optionally blanked.
    initial begin
        logic stall_prev;
        stall_prev = 1'b1;
        ser_axiov  = 1'b0;
        forever begin
            @(negedge clk);
            if (block_left > 0) begin
                ser_axiov = 1'b0;
                block_left--;
            end else begin
                ser_axiov = !stall_prev;
            end
            stall_prev = stall;
        end
    end

    // Monitor: every output pulse must match the next expected event.
    initial begin
        logic [4:0] pulses;
        ev_t e;
        forever begin
            @(negedge clk);
            pulses = {aborted, overrun, frame_done, pkt_done, pkt_start};
            for (int k = 0; k < 5; k++) begin
                if (pulses[k]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_%s: seen at cycle %0d pkt_count %0d, required no pulse",
                                 kname(k), cyc, pkt_count);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.kind != k || e.cyc != cyc || e.pc != int'(pkt_count)) begin
                            n_errors++;
                            $display("FAIL event: got %s at cycle %0d pkt_count %0d, required %s at cycle %0d pkt_count %0d",
                                     kname(k), cyc, pkt_count, kname(e.kind), e.cyc, e.pc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        n_errors++;
        $display("FAIL watchdog: time limit reached, required bench completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        int p;
        rst       = 1'b1;
        frame_req = 1'b0;
        tx_ready  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int unsigned i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_stall", stall, 1);
            check("idle_busy", busy, 0);
        end
        check("idle_pkt_count", pkt_count, 0);

        // Request with the link down is dropped silently.
        tx_ready  = 1'b0;
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        check("nolink_busy", busy, 0);
        check("nolink_stall", stall, 1);
        @(negedge clk);
        tx_ready = 1'b1;

        // Full frame.
        p = cyc + 2;
        push_frame(p, 0, 1'b0);
        pulse_req(p);
        wait_cyc(p + DONE_OFS + 1);
        check("gap_stall", stall, 1);
        check("gap_busy", busy, 1);
        wait_cyc(p + FRAME_END + 4);
        check("frame_end_busy", busy, 0);

        // Valid held low for 5 mid-packet cycles shifts the rest by 5.
        p = cyc + 2;
        push_frame(p, 5, 1'b0);
        pulse_req(p);
        wait_cyc(p + 100);
        @(posedge clk);
        #1 block_left = 5;
        wait_cyc(p + FRAME_END + 5 + 4);

        // Overrun during the first gap; frame otherwise unchanged.
        p = cyc + 2;
        push_frame(p, 0, 1'b1);
        pulse_req(p);
        wait_cyc(p + DONE_OFS);
        frame_req = 1'b1;
        @(negedge clk);
        frame_req = 1'b0;
        wait_cyc(p + FRAME_END + 4);

        // Link drop at dibit 600 of packet 1.
        p = cyc + 2;
        push(0, p, 0);
        push(1, p + DONE_OFS, 0);
        push(0, p + PERIOD, 1);
        push(4, p + PERIOD + 601, 1);
        pulse_req(p);
        wait_cyc(p + PERIOD + 600);
        tx_ready = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_stall", stall, 1);
        check("abort_pkt_count", pkt_count, 1);
        tx_ready = 1'b1;
        wait_cyc(p + PERIOD + 620);
        check("abort_stays_idle", busy, 0);

        // Link drop and frame request together in GAP: both pulse, no restart.
        p = cyc + 2;
        push(0, p, 0);
        push(1, p + DONE_OFS, 0);
        push(3, p + DONE_OFS + 1, 0);
        push(4, p + DONE_OFS + 1, 0);
        pulse_req(p);
        wait_cyc(p + DONE_OFS);
        frame_req = 1'b1;
        tx_ready  = 1'b0;
        @(negedge clk);
        frame_req = 1'b0;
        tx_ready  = 1'b1;
        check("abort_ovr_busy", busy, 0);
        wait_cyc(p + DONE_OFS + 12);
        check("abort_ovr_not_queued", busy, 0);

`ifdef PACKET_SCHEDULER_STATS_EN
        check("frames_sent", frames_sent, 3);
        check("aborts_seen", aborts_seen, 2);
`endif

        // Reset in the middle of packet 1.
        p = cyc + 2;
        push(0, p, 0);
        push(1, p + DONE_OFS, 0);
        push(0, p + PERIOD, 1);
        pulse_req(p);
        wait_cyc(p + PERIOD + 102);
        check("pre_reset_pkt_count", pkt_count, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_stall", stall, 1);
        check("reset_busy", busy, 0);
        check("reset_pkt_count", pkt_count, 0);
`ifdef PACKET_SCHEDULER_STATS_EN
        check("reset_frames_sent", frames_sent, 0);
        check("reset_aborts_seen", aborts_seen, 0);
`endif
        repeat (20) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
